accumulator_drain: RTL and testbench

Output stage directly downstream of `computation_subunit`. On a capture strobe it snapshots the subunit's sixteen 22-bit accumulators. It then applies optional ReLU, rounding right-shift and signed saturation to 8 bits, and streams the results out one per cycle over a valid/ready handshake. This frees the subunit to start the next output position while the previous one is still being written back.

---
 rtl/accumulator_drain.sv | 158 +++++++++++++++
 tb/tb_accumulator_drain.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/accumulator_drain.sv
// Output stage behind computation_subunit: snapshots sixteen accumulators on capture,
// quantises each one (ReLU, rounding shift, saturation) and streams them over valid/ready.
module accumulator_drain #(
    parameter int ACC_BIT_WIDTH   = 22,
    parameter int INPUT_BIT_WIDTH = 8,
    parameter int NUM_CHANNELS    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ACC_BIT_WIDTH-1:0]   accumulator_0,
    input  logic [ACC_BIT_WIDTH-1:0]   accumulator_1,
    input  logic [ACC_BIT_WIDTH-1:0]   accumulator_2,
    input  logic [ACC_BIT_WIDTH-1:0]   accumulator_3,
    input  logic [ACC_BIT_WIDTH-1:0]   accumulator_4,
    input  logic [ACC_BIT_WIDTH-1:0]   accumulator_5,
    input  logic [ACC_BIT_WIDTH-1:0]   accumulator_6,
    input  logic [ACC_BIT_WIDTH-1:0]   accumulator_7,
    input  logic [ACC_BIT_WIDTH-1:0]   accumulator_8,
    input  logic [ACC_BIT_WIDTH-1:0]   accumulator_9,
    input  logic [ACC_BIT_WIDTH-1:0]   accumulator_10,
    input  logic [ACC_BIT_WIDTH-1:0]   accumulator_11,
    input  logic [ACC_BIT_WIDTH-1:0]   accumulator_12,
    input  logic [ACC_BIT_WIDTH-1:0]   accumulator_13,
    input  logic [ACC_BIT_WIDTH-1:0]   accumulator_14,
    input  logic [ACC_BIT_WIDTH-1:0]   accumulator_15,
    input  logic                       capture,
    input  logic [4:0]                 num_active,
    input  logic [4:0]                 shift,
    input  logic                       relu_en,
    output logic [INPUT_BIT_WIDTH-1:0] out_data,
    output logic [3:0]                 out_index,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       overrun
);

    localparam int XW = ACC_BIT_WIDTH + 1;
    localparam logic signed [XW-1:0] SAT_MAX = XW'((1 << (INPUT_BIT_WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t state, state_nxt;

    logic [ACC_BIT_WIDTH-1:0] acc_in [NUM_CHANNELS];
    logic [ACC_BIT_WIDTH-1:0] snap   [NUM_CHANNELS];
    logic [4:0]               shift_r;
    logic                     relu_r;
    logic [4:0]               count_r;
    logic [3:0]               index;
    logic [3:0]               index_nxt;
    logic [4:0]               eff_count;
    logic                     handshake;
    logic                     last;
    logic                     accept;

    assign acc_in[0]  = accumulator_0;
    assign acc_in[1]  = accumulator_1;
    assign acc_in[2]  = accumulator_2;
    assign acc_in[3]  = accumulator_3;
    assign acc_in[4]  = accumulator_4;
    assign acc_in[5]  = accumulator_5;
    assign acc_in[6]  = accumulator_6;
    assign acc_in[7]  = accumulator_7;
    assign acc_in[8]  = accumulator_8;
    assign acc_in[9]  = accumulator_9;
    assign acc_in[10] = accumulator_10;
    assign acc_in[11] = accumulator_11;
    assign acc_in[12] = accumulator_12;
    assign acc_in[13] = accumulator_13;
    assign acc_in[14] = accumulator_14;
    assign acc_in[15] = accumulator_15;

    // One extra bit of headroom keeps the rounding add from overflowing.
    function automatic logic [INPUT_BIT_WIDTH-1:0] quantise(
        input logic [ACC_BIT_WIDTH-1:0] acc,
        input logic [4:0]               sh,
        input logic                     relu
    );
        logic signed [XW-1:0] x;
        logic signed [XW-1:0] rnd;
        x   = {acc[ACC_BIT_WIDTH-1], acc};
        rnd = '0;
        if (relu && x < 0)
            x = '0;
        if (sh != 5'd0) begin
            rnd = XW'(1) <<< (sh - 5'd1);
            x   = (x + rnd) >>> sh;
        end
        if (x > SAT_MAX)
            return SAT_MAX[INPUT_BIT_WIDTH-1:0];
        else if (x < SAT_MIN)
            return SAT_MIN[INPUT_BIT_WIDTH-1:0];
        else
            return x[INPUT_BIT_WIDTH-1:0];
    endfunction

    assign eff_count = (num_active == 5'd0 || num_active > 5'(NUM_CHANNELS))
                     ? 5'(NUM_CHANNELS) : num_active;
    assign handshake = out_valid && out_ready;
    assign last      = (5'(index) == count_r - 5'd1);
    assign index_nxt = index + 4'd1;
    // A capture landing on the final handshake chains straight into the next drain.
    assign accept    = capture && (state == IDLE || (handshake && last));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = DRAIN;
            DRAIN: if (handshake && last && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == DRAIN);
        out_valid = (state == DRAIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++)
                snap[i] <= '0;
            shift_r   <= '0;
            relu_r    <= 1'b0;
            count_r   <= '0;
            index     <= '0;
            out_data  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (capture && state == DRAIN && !accept)
                overrun <= 1'b1;
            if (accept) begin
                for (int unsigned i = 0; i < NUM_CHANNELS; i++)
                    snap[i] <= acc_in[i];
                shift_r  <= shift;
                relu_r   <= relu_en;
                count_r  <= eff_count;
                index    <= '0;
                out_data <= quantise(acc_in[0], shift, relu_en);
            end else if (handshake && !last) begin
                index    <= index_nxt;
                out_data <= quantise(snap[index_nxt], shift_r, relu_r);
            end
        end
    end

    assign out_index = index;

endmodule

// File: tb/tb_accumulator_drain.sv
// Directed bench for accumulator_drain: hand-computed expected outputs checked with
// immediate assertions along one linear stimulus sequence.
module tb_accumulator_drain;

    logic        clk;
    logic        reset;
    logic [21:0] acc [16];
    logic        capture;
    logic [4:0]  num_active;
    logic [4:0]  shift;
    logic        relu_en;
    logic [7:0]  out_data;
    logic [3:0]  out_index;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;
    int hs;

    accumulator_drain #(
        .ACC_BIT_WIDTH(22),
        .INPUT_BIT_WIDTH(8),
        .NUM_CHANNELS(16)
    ) dut (
        .clk(clk), .reset(reset),
        .accumulator_0(acc[0]),   .accumulator_1(acc[1]),
        .accumulator_2(acc[2]),   .accumulator_3(acc[3]),
        .accumulator_4(acc[4]),   .accumulator_5(acc[5]),
        .accumulator_6(acc[6]),   .accumulator_7(acc[7]),
        .accumulator_8(acc[8]),   .accumulator_9(acc[9]),
        .accumulator_10(acc[10]), .accumulator_11(acc[11]),
        .accumulator_12(acc[12]), .accumulator_13(acc[13]),
        .accumulator_14(acc[14]), .accumulator_15(acc[15]),
        .capture(capture), .num_active(num_active), .shift(shift), .relu_en(relu_en),
        .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [21:0] v);
        for (int i = 0; i < 16; i++) acc[i] = v;
    endtask

    initial begin
        reset = 1'b1; capture = 1'b0; num_active = '0; shift = '0; relu_en = 1'b0;
        out_ready = 1'b0;
        set_all('0);
        step(); step();
        chk("rst_data", out_data, 0);
        chk("rst_index", out_index, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;
        step();

        // Full 16-channel drain: (256 + 8) >>> 4 = 16
        set_all(22'd256); shift = 5'd4; num_active = 5'd0; out_ready = 1'b1;
        capture = 1'b1; step(); capture = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("full_valid", out_valid, 1);
            chk("full_index", out_index, i);
            chk("full_data", out_data, 8'h10);
            chk("full_busy", busy, 1);
            step();
        end
        chk("full_end_valid", out_valid, 0);
        chk("full_end_busy", busy, 0);

        // Rounding and saturation
        set_all('0);
        acc[0] = 22'd24; acc[1] = 22'd23; acc[2] = -22'sd4096;
        acc[3] = 22'h0FFFFF; acc[4] = -22'sd20;
        num_active = 5'd5; shift = 5'd4;
        capture = 1'b1; step(); capture = 1'b0;
        chk("rnd_24", out_data, 8'h02); step();
        chk("rnd_23", out_data, 8'h01); step();
        chk("sat_neg", out_data, 8'h80); step();
        chk("sat_pos", out_data, 8'h7F); step();
        chk("rnd_m20", out_data, 8'hFF);
        chk("rnd_last_idx", out_index, 4); step();
        chk("rnd_end_valid", out_valid, 0);

        // ReLU with shift 0
        acc[0] = -22'sd20; acc[1] = -22'sd4096; acc[2] = 22'd100;
        num_active = 5'd3; shift = 5'd0; relu_en = 1'b1;
        capture = 1'b1; step(); capture = 1'b0;
        chk("relu_m20", out_data, 8'h00); step();
        chk("relu_m4096", out_data, 8'h00); step();
        chk("relu_100", out_data, 8'h64); step();
        chk("relu_end_valid", out_valid, 0);

        // Backpressure: ready pattern 1,0,0,1,0,0,...
        relu_en = 1'b0;
        acc[0] = 22'd1; acc[1] = 22'd2; acc[2] = 22'd3;
        capture = 1'b1; step(); capture = 1'b0;
        hs = 0;
        for (int c = 0; c < 12 && hs < 3; c++) begin
            out_ready = (c % 3 == 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_index", out_index, hs);
            chk("bp_data", out_data, hs + 1);
            step();
            if (out_ready) hs++;
        end
        chk("bp_end_valid", out_valid, 0);
        chk("bp_end_busy", busy, 0);
        out_ready = 1'b1;

        // Overrun at index 5, then chained capture on the final handshake
        for (int i = 0; i < 16; i++) acc[i] = 22'(i * 16);
        num_active = 5'd0; shift = 5'd4;
        capture = 1'b1; step(); capture = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("ovr_index", out_index, i);
            chk("ovr_data", out_data, i);
            if (i == 0) chk("ovr_clear", overrun, 0);
            if (i == 6) chk("ovr_set", overrun, 1);
            if (i == 5) begin
                set_all(22'd1600);
                capture = 1'b1;
            end
            if (i == 15) begin
                for (int j = 0; j < 16; j++) acc[j] = 22'((j + 32) * 16);
                num_active = 5'd2;
                capture = 1'b1;
            end
            step();
            capture = 1'b0;
        end
        chk("chain_valid", out_valid, 1);
        chk("chain_busy", busy, 1);
        chk("chain_index0", out_index, 0);
        chk("chain_data0", out_data, 32);
        step();
        chk("chain_index1", out_index, 1);
        chk("chain_data1", out_data, 33);
        step();
        chk("chain_end_valid", out_valid, 0);

        // Reset mid-drain at index 7
        for (int i = 0; i < 16; i++) acc[i] = 22'(i * 16);
        num_active = 5'd0;
        capture = 1'b1; step(); capture = 1'b0;
        repeat (7) step();
        chk("mid_index", out_index, 7);
        chk("mid_data", out_data, 7);
        chk("mid_overrun", overrun, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_overrun", overrun, 0);
        chk("arst_data", out_data, 0);
        chk("arst_index", out_index, 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) acc[i] = 22'((i + 50) * 16);
        num_active = 5'd2;
        capture = 1'b1; step(); capture = 1'b0;
        chk("restart_valid", out_valid, 1);
        chk("restart_index", out_index, 0);
        chk("restart_data", out_data, 50);
        step();
        chk("restart_data1", out_data, 51);
        step();
        chk("restart_end_valid", out_valid, 0);
        chk("restart_overrun", overrun, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
